// File: rtl/axil_rr_arbiter.sv
// N-master to 1-slave AXI4-Lite arbiter. Read and write directions each run their own
// FSM and arbitration pointer, so one master can stream reads while another writes.
module axil_rr_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int RR_MODE     = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_MASTERS*ADDR_W-1:0]   m_araddr,
    input  logic [NUM_MASTERS-1:0]          m_arvalid,
    output logic [NUM_MASTERS-1:0]          m_arready,
    output logic [DATA_W-1:0]               m_rdata,
    output logic [NUM_MASTERS-1:0]          m_rvalid,
    input  logic [NUM_MASTERS-1:0]          m_rready,
    input  logic [NUM_MASTERS*ADDR_W-1:0]   m_awaddr,
    input  logic [NUM_MASTERS-1:0]          m_awvalid,
    output logic [NUM_MASTERS-1:0]          m_awready,
    input  logic [NUM_MASTERS*DATA_W-1:0]   m_wdata,
    input  logic [NUM_MASTERS*DATA_W/8-1:0] m_wstrb,
    input  logic [NUM_MASTERS-1:0]          m_wvalid,
    output logic [NUM_MASTERS-1:0]          m_wready,
    output logic [NUM_MASTERS-1:0]          m_bvalid,
    input  logic [NUM_MASTERS-1:0]          m_bready,
    output logic [ADDR_W-1:0]               s_araddr,
    output logic                            s_arvalid,
    input  logic                            s_arready,
    input  logic [DATA_W-1:0]               s_rdata,
    input  logic                            s_rvalid,
    output logic                            s_rready,
    output logic [ADDR_W-1:0]               s_awaddr,
    output logic                            s_awvalid,
    input  logic                            s_awready,
    output logic [DATA_W-1:0]               s_wdata,
    output logic [DATA_W/8-1:0]             s_wstrb,
    output logic                            s_wvalid,
    input  logic                            s_wready,
    input  logic                            s_bvalid,
    output logic                            s_bready,
    output logic [NUM_MASTERS-1:0]          rd_grant,
    output logic [NUM_MASTERS-1:0]          wr_grant
);

    localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int SW = DATA_W / 8;

    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rd_state_e;
    typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP} wr_state_e;

    rd_state_e       rd_state_q, rd_state_d;
    wr_state_e       wr_state_q, wr_state_d;
    logic [IW-1:0]   rd_idx_q, rd_idx_d, rd_ptr_q, rd_ptr_d;
    logic [IW-1:0]   wr_idx_q, wr_idx_d, wr_ptr_q, wr_ptr_d;
    logic            aw_done_q, aw_done_d, w_done_q, w_done_d;

    // Requester with the smallest upward distance from ptr wins; fixed mode uses the raw index.
    function automatic logic [IW-1:0] pick(input logic [NUM_MASTERS-1:0] req,
                                           input logic [IW-1:0] ptr);
        logic [IW-1:0] sel;
        int            best, d;
        sel  = '0;
        best = NUM_MASTERS;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            d = (RR_MODE != 0) ? (i - int'(ptr) + NUM_MASTERS) % NUM_MASTERS : i;
            if (req[i] && d < best) begin
                best = d;
                sel  = IW'(i);
            end
        end
        return sel;
    endfunction

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
        return (int'(i) >= NUM_MASTERS - 1) ? '0 : IW'(int'(i) + 1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state_q <= R_IDLE;
            rd_idx_q   <= '0;
            rd_ptr_q   <= '0;
            wr_state_q <= W_IDLE;
            wr_idx_q   <= '0;
            wr_ptr_q   <= '0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
        end else begin
            rd_state_q <= rd_state_d;
            rd_idx_q   <= rd_idx_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_state_q <= wr_state_d;
            wr_idx_q   <= wr_idx_d;
            wr_ptr_q   <= wr_ptr_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
        end
    end

    // Grants come only from registered state, never straight from the request lines.
    always_comb begin
        rd_grant = '0;
        wr_grant = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            rd_grant[i] = (rd_state_q != R_IDLE) && (rd_idx_q == IW'(i));
            wr_grant[i] = (wr_state_q != W_IDLE) && (wr_idx_q == IW'(i));
        end
    end

    always_comb begin
        rd_state_d = rd_state_q;
        rd_idx_d   = rd_idx_q;
        rd_ptr_d   = rd_ptr_q;
        case (rd_state_q)
            R_IDLE: if (|m_arvalid) begin
                rd_idx_d   = pick(m_arvalid, rd_ptr_q);
                rd_state_d = R_ADDR;
            end
            R_ADDR: if (s_arvalid && s_arready) rd_state_d = R_DATA;
            R_DATA: if (s_rvalid && s_rready) begin
                rd_state_d = R_IDLE;
                rd_ptr_d   = next_idx(rd_idx_q);
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        s_araddr  = '0;
        s_arvalid = 1'b0;
        m_arready = '0;
        m_rvalid  = '0;
        m_rdata   = '0;
        s_rready  = 1'b0;
        case (rd_state_q)
            R_ADDR: begin
                for (int i = 0; i < NUM_MASTERS; i++)
                    s_araddr = s_araddr | (m_araddr[i*ADDR_W +: ADDR_W] & {ADDR_W{rd_grant[i]}});
                s_arvalid = |(m_arvalid & rd_grant);
                m_arready = rd_grant & {NUM_MASTERS{s_arready}};
            end
            R_DATA: begin
                m_rvalid = rd_grant & {NUM_MASTERS{s_rvalid}};
                s_rready = |(m_rready & rd_grant);
                m_rdata  = s_rdata;
            end
            default: ;
        endcase
    end

    always_comb begin
        wr_state_d = wr_state_q;
        wr_idx_d   = wr_idx_q;
        wr_ptr_d   = wr_ptr_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        case (wr_state_q)
            W_IDLE: if (|(m_awvalid | m_wvalid)) begin
                wr_idx_d   = pick(m_awvalid | m_wvalid, wr_ptr_q);
                wr_state_d = W_REQ;
                aw_done_d  = 1'b0;
                w_done_d   = 1'b0;
            end
            // AW and W complete independently, in either order or together.
            W_REQ: begin
                aw_done_d = aw_done_q | (s_awvalid & s_awready);
                w_done_d  = w_done_q | (s_wvalid & s_wready);
                if (aw_done_d && w_done_d) wr_state_d = W_RESP;
            end
            W_RESP: if (s_bvalid && s_bready) begin
                wr_state_d = W_IDLE;
                wr_ptr_d   = next_idx(wr_idx_q);
                aw_done_d  = 1'b0;
                w_done_d   = 1'b0;
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        s_awaddr  = '0;
        s_awvalid = 1'b0;
        m_awready = '0;
        s_wdata   = '0;
        s_wstrb   = '0;
        s_wvalid  = 1'b0;
        m_wready  = '0;
        m_bvalid  = '0;
        s_bready  = 1'b0;
        case (wr_state_q)
            W_REQ: begin
                for (int i = 0; i < NUM_MASTERS; i++) begin
                    s_awaddr = s_awaddr | (m_awaddr[i*ADDR_W +: ADDR_W] & {ADDR_W{wr_grant[i]}});
                    s_wdata  = s_wdata  | (m_wdata[i*DATA_W +: DATA_W]  & {DATA_W{wr_grant[i]}});
                    s_wstrb  = s_wstrb  | (m_wstrb[i*SW +: SW]          & {SW{wr_grant[i]}});
                end
                s_awvalid = |(m_awvalid & wr_grant) & ~aw_done_q;
                m_awready = wr_grant & {NUM_MASTERS{s_awready & ~aw_done_q}};
                s_wvalid  = |(m_wvalid & wr_grant) & ~w_done_q;
                m_wready  = wr_grant & {NUM_MASTERS{s_wready & ~w_done_q}};
            end
            W_RESP: begin
                m_bvalid = wr_grant & {NUM_MASTERS{s_bvalid}};
                s_bready = |(m_bready & wr_grant);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_axil_rr_arbiter.sv
// Scoreboard bench: a round-robin and a fixed-priority 3-master arbiter behind zero-wait
// slave models; directed stimulus queues expected beats, negedge monitors pop and compare.
module tb_axil_rr_arbiter;
    localparam int N = 3, AW = 32, DW = 32, SW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [AW-1:0] ar_a [N];
    logic [AW-1:0] aw_a [N];
    logic [DW-1:0] wd   [N];
    logic [SW-1:0] ws   [N];
    logic [N*AW-1:0] m_araddr, m_awaddr;
    logic [N*DW-1:0] m_wdata;
    logic [N*SW-1:0] m_wstrb;
    assign m_araddr = {ar_a[2], ar_a[1], ar_a[0]};
    assign m_awaddr = {aw_a[2], aw_a[1], aw_a[0]};
    assign m_wdata  = {wd[2], wd[1], wd[0]};
    assign m_wstrb  = {ws[2], ws[1], ws[0]};

    logic [N-1:0] m_arvalid, m_arready, m_rvalid, m_rready, m_awvalid, m_awready;
    logic [N-1:0] m_wvalid, m_wready, m_bvalid, m_bready, rd_grant, wr_grant;
    logic [DW-1:0] m_rdata, s_rdata, s_wdata;
    logic [AW-1:0] s_araddr, s_awaddr;
    logic [SW-1:0] s_wstrb;
    logic s_arvalid, s_arready, s_rvalid, s_rready, s_awvalid, s_awready;
    logic s_wvalid, s_wready, s_bvalid, s_bready;

    // fixed-priority instance: read path only
    logic [N-1:0] f_arvalid, f_arready, f_rvalid, f_awready, f_wready, f_bvalid, f_rd_grant, f_wr_grant;
    logic [DW-1:0] f_rdata, f_s_rdata, f_s_wdata;
    logic [AW-1:0] f_s_araddr, f_s_awaddr;
    logic [SW-1:0] f_s_wstrb;
    logic f_s_arvalid, f_s_rvalid, f_s_rready, f_s_awvalid, f_s_wvalid, f_s_bready;

    axil_rr_arbiter #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(1)) dut (
        .clk(clk), .rst(rst),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bvalid(m_bvalid), .m_bready(m_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bvalid(s_bvalid), .s_bready(s_bready),
        .rd_grant(rd_grant), .wr_grant(wr_grant));

    axil_rr_arbiter #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(0)) dut_fp (
        .clk(clk), .rst(rst),
        .m_araddr(m_araddr), .m_arvalid(f_arvalid), .m_arready(f_arready),
        .m_rdata(f_rdata), .m_rvalid(f_rvalid), .m_rready({N{1'b1}}),
        .m_awaddr({N*AW{1'b0}}), .m_awvalid({N{1'b0}}), .m_awready(f_awready),
        .m_wdata({N*DW{1'b0}}), .m_wstrb({N*SW{1'b0}}), .m_wvalid({N{1'b0}}), .m_wready(f_wready),
        .m_bvalid(f_bvalid), .m_bready({N{1'b1}}),
        .s_araddr(f_s_araddr), .s_arvalid(f_s_arvalid), .s_arready(1'b1),
        .s_rdata(f_s_rdata), .s_rvalid(f_s_rvalid), .s_rready(f_s_rready),
        .s_awaddr(f_s_awaddr), .s_awvalid(f_s_awvalid), .s_awready(1'b0),
        .s_wdata(f_s_wdata), .s_wstrb(f_s_wstrb), .s_wvalid(f_s_wvalid), .s_wready(1'b0),
        .s_bvalid(1'b0), .s_bready(f_s_bready),
        .rd_grant(f_rd_grant), .wr_grant(f_wr_grant));

    // zero-wait slave models: read data = address + 0x1000_0000
    logic aw_got, w_got, aw_n, w_n;
    initial begin s_rdata = '0; f_s_rdata = '0; end
    always @(posedge clk) begin
        if (rst) s_rvalid <= 1'b0;
        else if (s_arvalid && s_arready) begin s_rvalid <= 1'b1; s_rdata <= s_araddr + 32'h1000_0000; end
        else if (s_rvalid && s_rready) s_rvalid <= 1'b0;
    end
    always @(posedge clk) begin
        if (rst) f_s_rvalid <= 1'b0;
        else if (f_s_arvalid) begin f_s_rvalid <= 1'b1; f_s_rdata <= f_s_araddr + 32'h1000_0000; end
        else if (f_s_rvalid && f_s_rready) f_s_rvalid <= 1'b0;
    end
    always_comb begin
        aw_n = aw_got | (s_awvalid & s_awready);
        w_n  = w_got | (s_wvalid & s_wready);
    end
    always @(posedge clk) begin
        if (rst) begin s_bvalid <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0; end
        else begin
            if (s_bvalid && s_bready) s_bvalid <= 1'b0;
            if (aw_n && w_n) begin s_bvalid <= 1'b1; aw_got <= 1'b0; w_got <= 1'b0; end
            else begin aw_got <= aw_n; w_got <= w_n; end
        end
    end

    int total = 0, passed = 0, aw_hs_cnt = 0, w_hs_cnt = 0;
    logic [34:0] rq[$], fq[$], re;
    logic [31:0] awq[$], ae;
    logic [35:0] wq[$], we;
    logic [2:0]  bq[$], be;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    always @(negedge clk) if (!rst) begin
        if (|(m_rvalid & m_rready)) begin
            if (rq.size() == 0) check("r_unexpected", {m_rvalid, m_rdata}, 0);
            else begin re = rq.pop_front(); check("r_beat", {m_rvalid, m_rdata}, re); end
        end
        if (|f_rvalid) begin
            if (fq.size() == 0) check("fp_r_unexpected", {f_rvalid, f_rdata}, 0);
            else begin re = fq.pop_front(); check("fp_r_beat", {f_rvalid, f_rdata}, re); end
        end
        if (s_awvalid && s_awready) begin
            aw_hs_cnt++;
            if (awq.size() == 0) check("aw_unexpected", s_awaddr, 0);
            else begin ae = awq.pop_front(); check("aw_addr", s_awaddr, ae); end
        end
        if (s_wvalid && s_wready) begin
            w_hs_cnt++;
            if (wq.size() == 0) check("w_unexpected", {s_wdata, s_wstrb}, 0);
            else begin we = wq.pop_front(); check("w_data_strb", {s_wdata, s_wstrb}, we); end
        end
        if (|(m_bvalid & m_bready)) begin
            if (bq.size() == 0) check("b_unexpected", m_bvalid, 0);
            else begin be = bq.pop_front(); check("b_owner", m_bvalid, be); end
        end
    end

    task automatic rd_req(input logic [1:0] i, input logic [31:0] a);
        ar_a[i] = a;
        m_arvalid[i] = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (m_arready[i]) begin @(posedge clk); #1 m_arvalid[i] = 1'b0; return; end
        end
        check("ar_timeout", 0, 1);
        m_arvalid[i] = 1'b0;
    endtask

    task automatic wr_req(input logic [1:0] i, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int lead);
        aw_a[i] = a; wd[i] = d; ws[i] = s;
        m_wvalid[i] = 1'b1;
        fork
            begin
                bit ok;
                ok = 1'b0;
                for (int c = 0; c < 50; c++) begin
                    @(negedge clk);
                    if (m_wready[i]) begin ok = 1'b1; break; end
                end
                if (!ok) check("w_timeout", 0, 1);
                @(posedge clk); #1 m_wvalid[i] = 1'b0;
            end
            begin
                bit ok;
                ok = 1'b0;
                if (lead > 0) begin repeat (lead) @(posedge clk); #1; end
                m_awvalid[i] = 1'b1;
                for (int c = 0; c < 50; c++) begin
                    @(negedge clk);
                    if (m_awready[i]) begin ok = 1'b1; break; end
                end
                if (!ok) check("aw_timeout", 0, 1);
                @(posedge clk); #1 m_awvalid[i] = 1'b0;
            end
        join
    endtask

    task automatic wait_drain();
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (rq.size() + fq.size() + awq.size() + wq.size() + bq.size() == 0) return;
        end
        check("drain_timeout", rq.size() + fq.size() + awq.size() + wq.size() + bq.size(), 0);
    endtask

    task automatic wait_srvalid();
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (s_rvalid) return;
        end
        check("rvalid_timeout", 0, 1);
    endtask

    initial begin
        int a0, w0;
        for (int i = 0; i < N; i++) begin ar_a[i] = '0; aw_a[i] = '0; wd[i] = '0; ws[i] = '0; end
        m_arvalid = '0; m_awvalid = '0; m_wvalid = '0; f_arvalid = '0;
        m_rready = '1; m_bready = '1;
        s_arready = 1'b1; s_awready = 1'b1; s_wready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("rst_grants", {rd_grant, wr_grant, f_rd_grant}, 0);
        check("rst_s_valids", {s_arvalid, s_awvalid, s_wvalid, s_rready, s_bready}, 0);
        check("rst_m_hs", {m_arready, m_awready, m_wready, m_rvalid, m_bvalid}, 0);
        check("rst_s_addr", {s_araddr, s_awaddr}, 0);
        check("rst_s_wdata", {s_wdata, s_wstrb}, 0);

        // two masters collide, pointer at 0: M0 then M1
        @(posedge clk); #1;
        rq.push_back({3'b001, 32'h9000_0000});
        rq.push_back({3'b010, 32'h9000_0100});
        fork
            rd_req(2'd0, 32'h8000_0000);
            rd_req(2'd1, 32'h8000_0100);
            begin
                repeat (2) @(negedge clk);
                check("rr_grant_first", rd_grant, 3'b001);
                repeat (2) @(negedge clk);
                check("rr_grant_bubble", rd_grant, 3'b000);
                @(negedge clk);
                check("rr_grant_second", rd_grant, 3'b010);
            end
        join
        wait_drain();

        // M0 reads while M1 writes
        @(posedge clk); #1;
        rq.push_back({3'b001, 32'h9000_0010});
        awq.push_back(32'h8000_0020);
        wq.push_back({32'hDEAD_BEEF, 4'hF});
        bq.push_back(3'b010);
        fork
            rd_req(2'd0, 32'h8000_0010);
            wr_req(2'd1, 32'h8000_0020, 32'hDEAD_BEEF, 4'hF, 0);
            begin
                repeat (2) @(negedge clk);
                check("conc_grants", {rd_grant, wr_grant}, {3'b001, 3'b010});
                @(negedge clk);
                check("conc_no_stall", {m_rvalid, m_bvalid}, {3'b001, 3'b010});
            end
        join
        wait_drain();

        // W leads AW by two cycles; slave takes AW a cycle after W
        @(posedge clk); #1;
        awq.push_back(32'h8000_0030);
        wq.push_back({32'h1234_5678, 4'b0011});
        bq.push_back(3'b100);
        s_awready = 1'b0;
        a0 = aw_hs_cnt; w0 = w_hs_cnt;
        fork
            wr_req(2'd2, 32'h8000_0030, 32'h1234_5678, 4'b0011, 2);
            begin
                for (int c = 0; c < 20; c++) begin
                    @(negedge clk);
                    if (s_wvalid && s_wready) break;
                end
                @(posedge clk); @(negedge clk);
                check("w_ready_after_done", m_wready, 0);
                check("aw_pending", {s_awvalid, wr_grant}, {1'b1, 3'b100});
                @(posedge clk); #1 s_awready = 1'b1;
            end
        join
        wait_drain();
        check("aw_hs_once", aw_hs_cnt - a0, 1);
        check("w_hs_once", w_hs_cnt - w0, 1);

        // slave rvalid held while master stalls
        @(posedge clk); #1;
        rq.push_back({3'b001, 32'h9000_0040});
        m_rready[0] = 1'b0;
        fork
            rd_req(2'd0, 32'h8000_0040);
            begin
                wait_srvalid();
                for (int k = 0; k < 4; k++) begin
                    check("bp_rready", s_rready, 0);
                    check("bp_grant", rd_grant, 3'b001);
                    check("bp_rdata", m_rdata, 32'h9000_0040);
                    @(negedge clk);
                end
                @(posedge clk); #1 m_rready[0] = 1'b1;
            end
        join
        wait_drain();

        // reset while M2 sits in R_DATA (pointer had moved to 2)
        @(posedge clk); #1;
        rq.push_back({3'b010, 32'h9000_0200});
        rd_req(2'd1, 32'h8000_0200);
        wait_drain();
        @(posedge clk); #1;
        m_rready[2] = 1'b0;
        rd_req(2'd2, 32'h8000_0300);
        wait_srvalid();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        m_rready[2] = 1'b1;
        @(negedge clk);
        check("rst_mid_grant", rd_grant, 0);
        check("rst_mid_valids", {m_rvalid, m_arready, s_arvalid, s_rready}, 0);
        @(posedge clk); #1;
        rq.push_back({3'b010, 32'h9000_0500});
        rq.push_back({3'b100, 32'h9000_0600});
        fork
            rd_req(2'd1, 32'h8000_0500);
            rd_req(2'd2, 32'h8000_0600);
        join
        wait_drain();

        // everyone requests continuously: 0,1,2,0,1,2 vs fixed 0 x6
        @(posedge clk); #1;
        ar_a[0] = 32'h100; ar_a[1] = 32'h200; ar_a[2] = 32'h300;
        for (int k = 0; k < 2; k++) begin
            rq.push_back({3'b001, 32'h1000_0100});
            rq.push_back({3'b010, 32'h1000_0200});
            rq.push_back({3'b100, 32'h1000_0300});
        end
        for (int k = 0; k < 6; k++) fq.push_back({3'b001, 32'h1000_0100});
        m_arvalid = '1; f_arvalid = '1;
        fork
            begin
                int cnt;
                cnt = 0;
                for (int c = 0; c < 200 && cnt < 6; c++) begin
                    @(negedge clk);
                    if (s_arvalid && s_arready) cnt++;
                end
                @(posedge clk); #1 m_arvalid = '0;
                if (cnt < 6) check("rr_ar_count", cnt, 6);
            end
            begin
                int cnt;
                cnt = 0;
                for (int c = 0; c < 200 && cnt < 6; c++) begin
                    @(negedge clk);
                    if (f_s_arvalid) cnt++;
                end
                @(posedge clk); #1 f_arvalid = '0;
                if (cnt < 6) check("fp_ar_count", cnt, 6);
            end
        join
        wait_drain();
        repeat (4) @(negedge clk);
        check("final_idle", {rd_grant, wr_grant, f_rd_grant}, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passed, total);
        $fatal(1);
    end
endmodule
